tick_period_meter: RTL
======================

# tick_period_meter

Measures the period, in `clock` cycles, of a single-cycle tick strobe such as the output of the modulo clock-divider counters, and recovers the divider modulo. It is the receiving end of the tick interface: the divider turns a modulo into ticks, and this block turns ticks back into a modulo. It reports each measured period, flags overflow, and asserts lock once two consecutive periods match. Typical uses are divider self-check and rate monitoring.

## Interface

Parameters:
- `BIT_SZ`, default 16: width of the period counter and the `period` output. The maximum measurable period is 2^BIT_SZ−1.

Ports:
- `clock`  in  1: clock.
- `sreset`  in  1: reset, synchronous, active-high; clock `clock`.
- `enable`  in  1: high enables measurement; low returns the block to IDLE.
- `tick_in`  in  1: tick strobe, synchronous to `clock`. Each high cycle is one tick; a constant high means period 1.
- `period`  out  BIT_SZ: last measured period in cycles.
- `period_valid`  out  1: one-cycle pulse when `period` updates.
- `overflow`  out  1: sticky; no tick arrived within 2^BIT_SZ−1 cycles.
- `locked`  out  1: the last two measurements were equal.

## Operation

- Internal state: `cnt` (BIT_SZ bits), `prev` (BIT_SZ bits), `have_prev` (1 bit).
- States:
  - **IDLE**: counting is stopped.
  - **ARMED**: waiting for a reference tick.
  - **MEASURE**: counting cycles since the last tick.
- Transitions and actions, in priority order:
  - `sreset` wins over everything. Outputs reset to `period`=0, `period_valid`=0, `overflow`=0, `locked`=0. Also clears `cnt`, `prev` and `have_prev`, and sets state to IDLE.
  - `enable`=0 in any state: go to IDLE, clear `cnt` and `have_prev`, set `locked`=0 and `period_valid`=0. `period` and `overflow` hold. If `tick_in` is high in the same cycle, it is ignored.
  - IDLE with `enable`=1: go to ARMED. A tick in that same cycle is ignored.
  - ARMED with `tick_in`=1: set `cnt`←1 and go to MEASURE. No measurement is produced.
  - MEASURE with `tick_in`=1:
    - Set `period`←`cnt`, pulse `period_valid`, then `prev`←`cnt`, `have_prev`←1, `cnt`←1, and clear `overflow`.
    - Set `locked`←(`have_prev` && `cnt`==`prev`), evaluated on pre-update values.
  - MEASURE with `tick_in`=0 and `cnt`<2^BIT_SZ−1: `cnt`←`cnt`+1.
  - MEASURE with `tick_in`=0 and `cnt`==2^BIT_SZ−1: set `overflow`←1, `locked`←0 and `have_prev`←0, then go to ARMED. The next tick only re-arms.
- Arithmetic: the counter never wraps. A tick arriving when `cnt`==2^BIT_SZ−1 is a valid measurement of 2^BIT_SZ−1.
- Period definition: ticks at cycles t and t+N yield `period`=N. For N≥1, a constant-high `tick_in` yields 1 every cycle.

## Timing

- All outputs are registered.
- Latency: for a tick sampled at edge t+N, `period`, `period_valid` and `locked` change at that same edge and are visible in cycle t+N+1.
- `period_valid` is high for exactly one cycle per measurement. With back-to-back ticks it is high every cycle.
- Measurement start:
  - The first measurement after enable or overflow needs two ticks.
  - `locked` needs at least three ticks after arming.
- `sreset` or `enable`=0 mid-count discards the partial count, with no `period_valid`.

## Structure

- Shared package `tick_meter_pkg` holds:
  - the state encoding `IDLE`=2'd0, `ARMED`=2'd1, `MEASURE`=2'd2;
  - the localparam `CNT_MAX` = {BIT_SZ{1'b1}}.
- No sub-module is needed: the single FSM, saturating counter and compare fit in one module. The bench instantiates `modulo_counter_16` as the stimulus source.

## Test plan

1. `modulo_counter_16` with modulo=5 drives `tick_in` with `enable`=1:
   - first `period_valid` arrives one cycle after the 2nd tick, with `period`=5 and `locked`=0;
   - after the 3rd tick, `period`=5 and `locked`=1;
   - pulses then repeat every 5 cycles.
2. `tick_in` held at 1 continuously: from the 3rd cycle after arming, `period`=1 and `period_valid`=1 every cycle; `locked`=1 from the following cycle.
3. BIT_SZ=4, one tick, then none for 20 cycles: `overflow`=1 with no `period_valid`. Ticks then at intervals of 3: the first re-arms, the next gives `period`=3 and clears `overflow`.
4. Divider changes modulo from 5 to 7 while locked: the first 7-measurement drops `locked` to 0; the next 7-measurement sets `locked`=1.
5. `enable` dropped 2 cycles into a count, coinciding with a tick: no `period_valid`, `locked`=0, `period` holds 5. Re-enable: two ticks are needed before the next valid.
6. `sreset` asserted mid-count and then released: all outputs read 0, and the block behaves as after power-up.

Source files
------------

// File: rtl/tick_meter_pkg.sv
// tick_meter_pkg: shared state encoding and counter limit for the tick period meter
package tick_meter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;
  localparam int BIT_SZ_DEF = 16;
  localparam logic [BIT_SZ_DEF-1:0] CNT_MAX = {BIT_SZ_DEF{1'b1}};
endpackage

// File: rtl/tick_period_meter.sv
// tick_period_meter: measures tick strobe period in clock cycles, flags overflow and lock
module tick_period_meter
  import tick_meter_pkg::*;
#(
  parameter int BIT_SZ = 16
) (
  input  logic              clock,
  input  logic              sreset,
  input  logic              enable,
  input  logic              tick_in,
  output logic [BIT_SZ-1:0] period,
  output logic              period_valid,
  output logic              overflow,
  output logic              locked
);
  localparam logic [BIT_SZ-1:0] cnt_max = {BIT_SZ{1'b1}};
  localparam logic [BIT_SZ-1:0] one = BIT_SZ'(1);
  state_t state_q, state_d;
  logic [BIT_SZ-1:0] cnt_q, cnt_d, prev_q, prev_d, period_q, period_d;
  logic have_prev_q, have_prev_d, valid_q, valid_d, ovf_q, ovf_d, locked_q, locked_d;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    period_d    = period_q;
    have_prev_d = have_prev_q;
    valid_d     = 1'b0;
    ovf_d       = ovf_q;
    locked_d    = locked_q;
    if (!enable) begin
      state_d     = IDLE;
      cnt_d       = '0;
      have_prev_d = 1'b0;
      locked_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (tick_in) begin
            cnt_d   = one;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (tick_in) begin
            period_d    = cnt_q;
            valid_d     = 1'b1;
            prev_d      = cnt_q;
            have_prev_d = 1'b1;
            cnt_d       = one;
            ovf_d       = 1'b0;
            locked_d    = have_prev_q && (cnt_q == prev_q);
          end else if (cnt_q != cnt_max) begin
            cnt_d = cnt_q + one;
          end else begin
            // saturated without a tick: the next tick only re-arms
            ovf_d       = 1'b1;
            locked_d    = 1'b0;
            have_prev_d = 1'b0;
            state_d     = ARMED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (sreset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prev_q      <= '0;
      period_q    <= '0;
      have_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      period_q    <= period_d;
      have_prev_q <= have_prev_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      locked_q    <= locked_d;
    end
  end
  assign period       = period_q;
  assign period_valid = valid_q;
  assign overflow     = ovf_q;
  assign locked       = locked_q;
endmodule
